// File: rtl/mem_req_unit.sv
// mem_req_unit
// Byte-addressable data memory behind a valid/ready request/response
// handshake. It holds one request at a time and answers LATENCY cycles after
// it accepts the request. It supports 1/2/4/8-byte little-endian accesses at
// any alignment, sign or zero extension of reads, and bounds checking.
//
// Storage is split into 8 byte-wide banks. Bank b holds every byte whose
// address satisfies addr[2:0] == b. An access of up to 8 bytes therefore
// touches each bank at most once, even when it is misaligned. Each bank is a
// plain array with one write port and one registered read port.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-low reset
//   req_valid   request present
//   req_ready   unit can accept a request (high only in IDLE)
//   req_write   1 = write, 0 = read
//   req_addr    byte address of the first byte
//   req_size    0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
//   req_signed  reads only: sign-extend the result
//   req_wdata   write data; the low (1<<req_size) bytes are used
//   resp_valid  response present
//   resp_ready  consumer accepts the response
//   resp_rdata  extended read data; 0 for writes and errors
//   resp_err    access ran past the end of memory
//   busy        unit is not idle
module mem_req_unit #(
    parameter int MEMSIZE = 524288,
    parameter int LATENCY = 2,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int NUM_BANKS = 8;
    localparam int BANK_ROWS = (MEMSIZE + 7) / 8;
    localparam int ROW_W     = (BANK_ROWS > 1) ? $clog2(BANK_ROWS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        write_reg, signed_reg, err_reg;
    logic [1:0]  size_reg;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;

    logic accept;
    logic commit;
    logic commit_fire;

    // ------------------------------------------------------------------
    // State machine: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = 32'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle latency commits on the accepting edge itself.
                        commit     = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 32'd1;
                if (cnt_reg == 32'd1) begin
                    commit     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A commit on a reset edge is discarded, so an aborted write never lands.
    assign commit_fire = commit & reset;

    // ------------------------------------------------------------------
    // State register and latched request
    // ------------------------------------------------------------------
    logic op_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            write_reg  <= 1'b0;
            signed_reg <= 1'b0;
            size_reg   <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg  <= req_write;
                signed_reg <= req_signed;
                size_reg   <= req_size;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
            end
            if (commit) begin
                err_reg <= op_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operation fields seen at the commit edge. With LATENCY==1 the commit
    // coincides with the accept, so the live request inputs are used.
    // ------------------------------------------------------------------
    logic        op_live;
    logic        op_write;
    logic [63:0] op_addr;
    logic [1:0]  op_size;
    logic [63:0] op_wdata;
    logic [3:0]  op_nbytes;
    logic [64:0] op_end;

    assign op_live   = (state_reg == ST_IDLE);
    assign op_write  = op_live ? req_write : write_reg;
    assign op_addr   = op_live ? req_addr  : addr_reg;
    assign op_size   = op_live ? req_size  : size_reg;
    assign op_wdata  = op_live ? req_wdata : wdata_reg;
    assign op_nbytes = 4'd1 << op_size;
    // The sum uses 65 bits so that an address near 2^64 cannot wrap into range.
    assign op_end    = {1'b0, op_addr} + 65'(op_nbytes);
    assign op_err    = op_end > 65'(MEMSIZE);

    // ------------------------------------------------------------------
    // Byte banks
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0][7:0] bank_rd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [7:0]       bank_mem [BANK_ROWS];
            logic [7:0]       rd_reg;
            logic [2:0]       lane;
            logic             hit;
            logic [ROW_W-1:0] row;

            // lane is the position within the access of the byte that falls in this bank.
            assign lane = 3'(gi) - op_addr[2:0];
            assign hit  = {1'b0, lane} < op_nbytes;
            // A bank below the start offset holds a byte that wraps into the next row.
            assign row  = op_addr[3 +: ROW_W] + ROW_W'(3'(gi) < op_addr[2:0]);

            always_ff @(posedge clk) begin
                if (commit_fire && op_write && !op_err && hit) begin
                    bank_mem[row] <= op_wdata[{lane, 3'b000} +: 8];
                end
                if (commit_fire && !op_write) begin
                    rd_reg <= bank_mem[row];
                end
            end

            assign bank_rd[gi] = rd_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read data assembly and extension
    // ------------------------------------------------------------------
    logic [3:0]  nbytes_reg;
    logic [63:0] raw;
    logic [63:0] ext;

    assign nbytes_reg = 4'd1 << size_reg;

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (4'(i) < nbytes_reg) begin
                raw[8*i +: 8] = bank_rd[addr_reg[2:0] + 3'(i)];
            end
        end
    end

    always_comb begin
        ext = raw;
        case (size_reg)
            2'd0: ext = {{56{signed_reg & raw[7]}},  raw[7:0]};
            2'd1: ext = {{48{signed_reg & raw[15]}}, raw[15:0]};
            2'd2: ext = {{32{signed_reg & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_err   = resp_valid & err_reg;
    assign resp_rdata = (resp_valid && !write_reg && !err_reg) ? DATA_W'(ext) : '0;

endmodule

// File: doc/mem_req_unit.md
Name: mem_req_unit

Overview:
- Byte-addressable data memory with a valid/ready request/response handshake and configurable access latency.
- Parametrised successor of the core's single-cycle memory unit; adds byte, half, word and dword accesses, sign/zero extension, bounds checking, and backpressure.
- Sits between the multicycle core's MEMORY state and the storage array.
- Holds one outstanding request at a time.

Parameters:
MEMSIZE, 524288, memory size in bytes; legal byte addresses are 0..MEMSIZE-1
LATENCY, 2, cycles from request accept to resp_valid; must be >= 1
DATA_W, 64, data width in bits; fixed at 64; size encoding covers up to 8 bytes

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset; sampled at posedge clk
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  64  byte address of first byte
req_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
req_signed  in  1  read only: sign-extend the result to 64 bits
req_wdata  in  64  write data; low (1<<req_size) bytes are used
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_rdata  out  64  read data, extended to 64 bits; 0 for writes and errors
resp_err  out  1  access out of bounds
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE and any pending request is dropped.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1, busy=0.
  - Memory contents are not cleared.
  - A write that has not reached commit is never performed.
- States:
  - IDLE: req_ready=1. When req_valid&&req_ready at posedge T, latch write/addr/size/signed/wdata and load cnt=LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: req_ready=0; cnt decrements each cycle. When cnt==1 at a posedge, commit and go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid&&resp_ready at a posedge, then go to IDLE.
- Timing:
  - resp_valid first rises LATENCY cycles after the accepting edge.
  - req_ready returns 1 the cycle after the response handshake; there is no same-cycle accept.
  - Maximum throughput is one access per LATENCY+1 cycles.
- Commit happens at the edge entering RESP:
  - Write: store bytes addr..addr+n-1, little-endian, where n = 1<<size. Other bytes are untouched.
  - Read: capture bytes addr..addr+n-1 little-endian. Zero-extend, or sign-extend from bit 8n-1 when signed=1. Size 3 ignores req_signed.
- Bounds:
  - Compute addr+n in 65 bits, so there is no 2^64 wrap.
  - If addr+n > MEMSIZE: resp_err=1, resp_rdata=0, no memory write.
- Alignment: misaligned addresses are legal and perform the full byte access.
- Request inputs are ignored while state != IDLE. Request fields only need to be stable in the accept cycle.
- resp_rdata=0 for all write responses.
- resp_ready high while resp_valid is low has no effect.

Test Plan:
1. After reset, write size3 addr 0x2000 data 0x1122334455667788, then read size2 signed=0 addr 0x2000 -> resp_rdata=0x0000000055667788, resp_err=0. Each resp_valid rises exactly 2 cycles after its accept edge; the write response has rdata=0.
2. Byte write 0x80 at 0x10 over a prefilled dword 0xAAAAAAAAAAAAAAAA:
   - Read size0 signed=1 -> 0xFFFFFFFFFFFFFF80.
   - Read size0 signed=0 -> 0x80.
   - Read size3 at 0x10 -> 0xAAAAAAAAAAAAAA80.
3. Bounds:
   - Read size3 addr MEMSIZE-4 -> resp_err=1, rdata=0.
   - Write size3 addr 0xFFFFFFFFFFFFFFFC -> resp_err=1, and a following read of addr 0..3 is unchanged.
   - Read size2 addr MEMSIZE-4 -> resp_err=0.
4. Backpressure: hold resp_ready=0 for 5 cycles while pulsing a second req_valid -> resp_valid, rdata and err stay stable, req_ready=0, and the second request is accepted only the cycle after the handshake.
5. Assert reset low for one cycle while in WAIT on a write of 0xDEADBEEF to 0x100 -> outputs return to reset values, and a later read of 0x100 returns the old data.
6. LATENCY=1 build: accept at edge T -> resp_valid at T+1. Back-to-back reads with resp_ready held at 1 complete one every 2 cycles.
